// File: rtl/tbuf_bus_arbiter.sv
// Round-robin owner sequencer for a shared TBUF tristate bus: one enabled
// driver bank at a time, with an all-off turnaround gap between grants.
module tbuf_bus_arbiter #(
  parameter int N_REQ       = 4,
  parameter int MAX_HOLD    = 8,
  parameter int TURN_CYCLES = 1,
  parameter int ID_W        = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] en,
  output logic [ID_W-1:0]  owner_id,
  output logic             bus_valid,
  output logic             turn,
  output logic             expired
);

  typedef enum logic [1:0] {IDLE, DRIVE, TURN} state_e;

  localparam logic [ID_W:0] N_L      = (ID_W+1)'(N_REQ);
  localparam logic [7:0]    HOLD_TOP = 8'(MAX_HOLD - 1);
  localparam logic [2:0]    TURN_TOP = 3'(TURN_CYCLES - 1);

  state_e             state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [7:0]         hold_cnt_q, hold_cnt_d;
  logic [2:0]         turn_cnt_q, turn_cnt_d;
  logic [N_REQ-1:0]   en_q, en_d;
  logic [ID_W-1:0]    owner_q, owner_d;
  logic               bus_valid_q, bus_valid_d;
  logic               turn_q, turn_d;
  logic               expired_q, expired_d;

  logic [ID_W-1:0]    sel;
  logic               sel_vld;
  logic [ID_W:0]      scan;
  logic [ID_W-1:0]    scan_idx;
  logic               owner_rel, hold_tmo;

  // Scan starting just after the last owner so it ends up lowest priority.
  always_comb begin
    sel      = '0;
    sel_vld  = 1'b0;
    scan     = '0;
    scan_idx = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      scan = {1'b0, rr_ptr_q} + (ID_W+1)'(i);
      if (scan >= N_L) scan = scan - N_L;
      scan_idx = scan[ID_W-1:0];
      if (!sel_vld && req[scan_idx]) begin
        sel_vld = 1'b1;
        sel     = scan_idx;
      end
    end
  end

  // Only the owner's request bit is looked at outside IDLE.
  assign owner_rel = !req[owner_q];
  assign hold_tmo  = (hold_cnt_q == HOLD_TOP);

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    hold_cnt_d  = hold_cnt_q;
    turn_cnt_d  = turn_cnt_q;
    en_d        = en_q;
    owner_d     = owner_q;
    bus_valid_d = bus_valid_q;
    turn_d      = 1'b0;
    expired_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel_vld) begin
          state_d     = DRIVE;
          en_d        = N_REQ'(1) << sel;
          owner_d     = sel;
          rr_ptr_d    = sel;
          hold_cnt_d  = '0;
          bus_valid_d = 1'b1;
        end
      end
      DRIVE: begin
        hold_cnt_d = (hold_cnt_q == 8'hFF) ? hold_cnt_q : hold_cnt_q + 8'd1;
        if (owner_rel || hold_tmo) begin
          state_d     = TURN;
          en_d        = '0;
          owner_d     = '0;
          bus_valid_d = 1'b0;
          turn_d      = 1'b1;
          turn_cnt_d  = '0;
          expired_d   = hold_tmo && !owner_rel;
        end
      end
      TURN: begin
        if (turn_cnt_q == TURN_TOP) begin
          state_d    = IDLE;
          turn_cnt_d = '0;
        end else begin
          turn_cnt_d = turn_cnt_q + 3'd1;
          turn_d     = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        en_d        = '0;
        owner_d     = '0;
        bus_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= ID_W'(N_REQ - 1);
      hold_cnt_q  <= '0;
      turn_cnt_q  <= '0;
      en_q        <= '0;
      owner_q     <= '0;
      bus_valid_q <= 1'b0;
      turn_q      <= 1'b0;
      expired_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      hold_cnt_q  <= hold_cnt_d;
      turn_cnt_q  <= turn_cnt_d;
      en_q        <= en_d;
      owner_q     <= owner_d;
      bus_valid_q <= bus_valid_d;
      turn_q      <= turn_d;
      expired_q   <= expired_d;
    end
  end

  assign en        = en_q;
  assign owner_id  = owner_q;
  assign bus_valid = bus_valid_q;
  assign turn      = turn_q;
  assign expired   = expired_q;

endmodule

// File: tb/tb_tbuf_bus_arbiter.sv
// Bench for tbuf_bus_arbiter: cycle model feeding a scoreboard queue, plus
// directed reset/contention/release cases and random-request invariants.
module tb_tbuf_bus_arbiter;

  localparam int N     = 4;
  localparam int MAXH  = 4;
  localparam int TURNC = 1;
  localparam int BOUND = 4 * (MAXH + 2);

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] en;
  logic [1:0]   owner_id;
  logic         bus_valid, turn, expired;

  tbuf_bus_arbiter #(.N_REQ(N), .MAX_HOLD(MAXH), .TURN_CYCLES(TURNC)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .en(en), .owner_id(owner_id),
    .bus_valid(bus_valid), .turn(turn), .expired(expired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] en;
    logic [1:0]   own;
    logic         bv;
    logic         turn;
    logic         exp;
  } exp_t;

  exp_t sb_q[$];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // reference model: 0 idle, 1 drive, 2 turn
  int m_st, m_own, m_ptr, m_len, m_tc;
  exp_t m_out;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_own = 0; m_ptr = N - 1; m_len = 0; m_tc = 0;
    m_out = '0;
  endtask

  task automatic model_edge(input logic [N-1:0] r);
    logic rel, tmo;
    int j;
    m_out.exp = 1'b0;
    case (m_st)
      0: begin
        m_out.turn = 1'b0;
        for (int k = 1; k <= N; k++) begin
          j = (m_ptr + k) % N;
          if (m_st == 0 && r[j]) begin
            m_st = 1; m_own = j; m_ptr = j; m_len = 1;
            m_out.en = '0; m_out.en[j] = 1'b1;
            m_out.own = 2'(j); m_out.bv = 1'b1;
          end
        end
      end
      1: begin
        rel = !r[m_own];
        tmo = (m_len == MAXH);
        if (rel || tmo) begin
          m_st = 2; m_tc = 1;
          m_out.en = '0; m_out.own = '0; m_out.bv = 1'b0;
          m_out.turn = 1'b1; m_out.exp = tmo && !rel;
        end else m_len++;
      end
      default: begin
        if (m_tc == TURNC) begin
          m_st = 0; m_out.turn = 1'b0;
        end else begin
          m_tc++; m_out.turn = 1'b1;
        end
      end
    endcase
  endtask

  task automatic step(input logic [N-1:0] r);
    exp_t e;
    req = r;
    @(posedge clk);
    cyc++;
    model_edge(r);
    sb_q.push_back(m_out);
    #1;
    e = sb_q.pop_front();
    chk("en", 32'(en), 32'(e.en));
    chk("owner_id", 32'(owner_id), 32'(e.own));
    chk("bus_valid", 32'(bus_valid), 32'(e.bv));
    chk("turn", 32'(turn), 32'(e.turn));
    chk("expired", 32'(expired), 32'(e.exp));
  endtask

  task automatic do_reset(input logic [N-1:0] r);
    req = r;
    rst_n = 1'b0;
    #1;
    chk("rst_en", 32'(en), 0);
    chk("rst_bv", 32'(bus_valid), 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_en", 32'(en), 0);
    chk("rst_hold_own", 32'(owner_id), 0);
    chk("rst_hold_turn", 32'(turn), 0);
    chk("rst_hold_exp", 32'(expired), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    cyc = 0;
  endtask

  logic [N-1:0] prev_en;
  logic [N-1:0] rr;
  int wait_c[N];
  int max_wait;

  initial begin
    model_reset();

    // reset with all requesting, then first grant to 0
    do_reset(4'b1111);
    step(4'b1111);
    chk("first_grant", 32'(en), 32'h1);

    // single requester released at cycle 3
    do_reset(4'b0000);
    for (int c = 1; c <= 6; c++) begin
      step((c <= 3) ? 4'b0100 : 4'b0000);
      if (c == 3) chk("single_en3", 32'(en), 32'h4);
      if (c == 4) begin
        chk("single_turn4", 32'(turn), 1);
        chk("single_en4", 32'(en), 0);
        chk("single_exp4", 32'(expired), 0);
      end
    end

    // full contention: 4-cycle grants, 2-cycle gaps, rotating owners
    do_reset(4'b1111);
    for (int c = 1; c <= 30; c++) begin
      int ph;
      logic [N-1:0] we;
      step(4'b1111);
      ph = (c - 1) % 6;
      we = '0;
      if (ph < 4) we[((c - 1) / 6) % N] = 1'b1;
      chk("cont_en", 32'(en), 32'(we));
      chk("cont_exp", 32'(expired), (ph == 4) ? 1 : 0);
      chk("cont_turn", 32'(turn), (ph == 4) ? 1 : 0);
    end

    // owner 1 releases on its final drive cycle: release, not expiry
    do_reset(4'b0000);
    for (int c = 1; c <= 7; c++) begin
      step((c <= 4) ? 4'b0110 : 4'b0100);
      if (c == 1) chk("rel_grant1", 32'(en), 32'h2);
      if (c == 5) begin
        chk("rel_turn", 32'(turn), 1);
        chk("rel_exp", 32'(expired), 0);
      end
      if (c == 6) chk("rel_idle_turn", 32'(turn), 0);
      if (c == 7) chk("rel_next2", 32'(en), 32'h4);
    end

    // asynchronous reset while owner 3 drives
    do_reset(4'b0000);
    step(4'b1000);
    chk("ar_pre", 32'(en), 32'h8);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_en", 32'(en), 0);
    chk("ar_bv", 32'(bus_valid), 0);
    chk("ar_turn", 32'(turn), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    cyc = 0;
    step(4'b1111);
    chk("ar_restart", 32'(en), 32'h1);

    // random requests with invariants
    do_reset(4'b0000);
    prev_en = '0;
    rr = '0;
    max_wait = 0;
    for (int i = 0; i < N; i++) wait_c[i] = 0;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(15) == 0) rr[i] = ~rr[i];
      step(rr);
      chk("onehot", 32'($countones(en) <= 1), 1);
      chk("gap", 32'(prev_en != '0 && en != '0 && en != prev_en), 0);
      for (int i = 0; i < N; i++) begin
        if (rr[i] && !en[i]) wait_c[i]++;
        else wait_c[i] = 0;
        if (wait_c[i] > max_wait) max_wait = wait_c[i];
      end
      prev_en = en;
    end
    chk("starve", 32'(max_wait <= BOUND), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
